// File: rtl/fpu_share_arbiter.sv
// Round-robin arbiter that time-shares one free-running FPU core among NREQ requesters.
// Operands are held on the FPU inputs for WAIT_CYCLES clocks, then the result is returned to the winner.
module fpu_share_arbiter #(
    parameter int NREQ        = 4,
    parameter int WAIT_CYCLES = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clock_100Khz,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_op_a,
    input  logic [32*NREQ-1:0]   req_op_b,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_data,
    output logic [3:0]           rsp_status,
    output logic [31:0]          fpu_op_a,
    output logic [31:0]          fpu_op_b,
    input  logic [31:0]          fpu_data_out,
    input  logic [3:0]           fpu_status,
    output logic                 busy,
    output logic [2:0]           grant_id,
    output logic [CNT_W-1:0]     ops_done
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_n_s;
    logic [CW-1:0]     cnt_r;
    logic [2:0]        rr_ptr_r;
    logic [2:0]        grant_id_r;
    logic [31:0]       op_a_r;
    logic [31:0]       op_b_r;
    logic [31:0]       rsp_data_r;
    logic [3:0]        rsp_status_r;
    logic [NREQ-1:0]   rsp_valid_r;
    logic [CNT_W-1:0]  ops_done_r;

    logic              win_found_s;
    logic [2:0]        win_idx_s;
    logic [3:0]        dist_s;
    logic [3:0]        best_dist_s;
    logic [31:0]       sel_a_s;
    logic [31:0]       sel_b_s;
    logic [NREQ-1:0]   grant_onehot_s;
    logic              rsp_done_s;
    logic [2:0]        rr_next_s;

    // Round-robin search: pick the valid requester closest to the pointer, counting upward with wrap.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        best_dist_s = 4'd15;
        dist_s      = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) >= rr_ptr_r) begin
                dist_s = 4'(i) - {1'b0, rr_ptr_r};
            end else begin
                dist_s = 4'(i) + 4'(NREQ) - {1'b0, rr_ptr_r};
            end
            if (req_valid[i] && (dist_s < best_dist_s)) begin
                win_found_s = 1'b1;
                win_idx_s   = 3'(i);
                best_dist_s = dist_s;
            end else begin
                best_dist_s = best_dist_s;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a_s = 32'd0;
        sel_b_s = 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_s == 3'(i)) begin
                sel_a_s = req_op_a[32*i +: 32];
                sel_b_s = req_op_b[32*i +: 32];
            end else begin
                sel_a_s = sel_a_s;
                sel_b_s = sel_b_s;
            end
        end
    end

    // One-hot accept strobe, only offered while idle.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_r == ST_IDLE) && win_found_s && (win_idx_s == 3'(i))) begin
                req_ready[i] = 1'b1;
            end else begin
                req_ready[i] = 1'b0;
            end
        end
    end

    // One-hot decode of the granted requester, used to raise its response valid.
    always_comb begin
        grant_onehot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_r == 3'(i)) begin
                grant_onehot_s[i] = 1'b1;
            end else begin
                grant_onehot_s[i] = 1'b0;
            end
        end
    end

    // Handshake completes only on the granted line; rsp_ready elsewhere is masked off.
    assign rsp_done_s = |(rsp_valid_r & rsp_ready);
    assign rr_next_s  = (grant_id_r == 3'(NREQ - 1)) ? 3'd0 : (grant_id_r + 3'd1);

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_n_s = ST_WAIT;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == '0) begin
                    state_n_s = ST_RESPOND;
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                if (rsp_done_s) begin
                    state_n_s = ST_IDLE;
                end else begin
                    state_n_s = ST_RESPOND;
                end
            end
            default: state_n_s = ST_IDLE;
        endcase
    end

    // State register and datapath; the operand registers keep their value between operations.
    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            rr_ptr_r     <= 3'd0;
            grant_id_r   <= 3'd0;
            op_a_r       <= 32'd0;
            op_b_r       <= 32'd0;
            rsp_data_r   <= 32'd0;
            rsp_status_r <= 4'd2;
            rsp_valid_r  <= '0;
            ops_done_r   <= '0;
        end else begin
            state_r <= state_n_s;
            case (state_r)
                ST_IDLE: begin
                    if (win_found_s) begin
                        op_a_r     <= sel_a_s;
                        op_b_r     <= sel_b_s;
                        grant_id_r <= win_idx_s;
                        cnt_r      <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == '0) begin
                        rsp_data_r   <= fpu_data_out;
                        rsp_status_r <= fpu_status;
                        rsp_valid_r  <= grant_onehot_s;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_RESPOND: begin
                    if (rsp_done_s) begin
                        rsp_valid_r <= '0;
                        ops_done_r  <= ops_done_r + CNT_W'(1);
                        rr_ptr_r    <= rr_next_s;
                    end
                end
                default: begin
                    rsp_valid_r <= '0;
                end
            endcase
        end
    end

    assign fpu_op_a   = op_a_r;
    assign fpu_op_b   = op_b_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_status = rsp_status_r;
    assign rsp_valid  = rsp_valid_r;
    assign grant_id   = grant_id_r;
    assign ops_done   = ops_done_r;
    assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Bench for fpu_share_arbiter: directed scenarios plus random traffic checked every cycle against a transaction-level model.
module tb_fpu_share_arbiter;

    localparam int NREQ        = 4;
    localparam int WAIT_CYCLES = 64;
    localparam int CNT_W       = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [32*NREQ-1:0]  req_op_a = '0;
    logic [32*NREQ-1:0]  req_op_b = '0;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ-1:0]     rsp_ready = '0;
    logic [31:0]         rsp_data;
    logic [3:0]          rsp_status;
    logic [31:0]         fpu_op_a;
    logic [31:0]         fpu_op_b;
    logic [31:0]         fpu_data_out;
    logic [3:0]          fpu_status;
    logic                busy;
    logic [2:0]          grant_id;
    logic [CNT_W-1:0]    ops_done;

    logic [31:0]         stub_mask = 32'd0;
    bit                  mask_rand = 1'b0;
    bit                  chk_en = 1'b0;
    int                  n_checks = 0;
    int                  n_pass = 0;

    fpu_share_arbiter #(.NREQ(NREQ), .WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) dut (
        .clock_100Khz(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op_a(req_op_a), .req_op_b(req_op_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_status(rsp_status),
        .fpu_op_a(fpu_op_a), .fpu_op_b(fpu_op_b),
        .fpu_data_out(fpu_data_out), .fpu_status(fpu_status),
        .busy(busy), .grant_id(grant_id), .ops_done(ops_done)
    );

    // FPU stub: combinational function of operands, perturbed by a bench-controlled mask.
    assign fpu_data_out = fpu_op_a ^ fpu_op_b ^ stub_mask;
    assign fpu_status   = stub_mask[3:0] ^ 4'd3;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int winner(input int rr, input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (rr + k) % NREQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Transaction-level model: remaining window length, pending response, pointer and count.
    int               m_left;
    bit               m_resp;
    int               m_grant;
    int               m_rr;
    logic [CNT_W-1:0] m_ops;
    logic [31:0]      m_fpa, m_fpb, m_data;
    logic [3:0]       m_stat;
    int               m_w;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0; m_resp <= 1'b0; m_grant <= 0; m_rr <= 0; m_ops <= '0;
            m_fpa <= 32'd0; m_fpb <= 32'd0; m_data <= 32'd0; m_stat <= 4'd2;
        end else if (m_resp) begin
            if (rsp_ready[m_grant]) begin
                m_resp <= 1'b0;
                m_ops  <= m_ops + 4'd1;
                m_rr   <= (m_grant + 1) % NREQ;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_resp <= 1'b1;
                m_data <= m_fpa ^ m_fpb ^ stub_mask;
                m_stat <= stub_mask[3:0] ^ 4'd3;
            end
        end else begin
            m_w = winner(m_rr, req_valid);
            if (m_w >= 0) begin
                m_grant <= m_w;
                m_fpa   <= req_op_a[32*m_w +: 32];
                m_fpb   <= req_op_b[32*m_w +: 32];
                m_left  <= WAIT_CYCLES;
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            bit              e_busy;
            int              w;
            logic [NREQ-1:0] e_rdy;
            logic [NREQ-1:0] e_rv;
            e_busy = m_resp || (m_left > 0);
            w = winner(m_rr, req_valid);
            e_rdy = (!e_busy && w >= 0) ? NREQ'(1 << w) : '0;
            e_rv  = m_resp ? NREQ'(1 << m_grant) : '0;
            check("req_ready", 32'(req_ready), 32'(e_rdy));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rv));
            check("busy", 32'(busy), 32'(e_busy));
            check("rsp_data", rsp_data, m_data);
            check("rsp_status", 32'(rsp_status), 32'(m_stat));
            check("fpu_op_a", fpu_op_a, m_fpa);
            check("fpu_op_b", fpu_op_b, m_fpb);
            check("grant_id", 32'(grant_id), 32'(m_grant));
            check("ops_done", 32'(ops_done), 32'(m_ops));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (mask_rand) stub_mask = $urandom;
        else stub_mask = 32'd0;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    int cnt;
    int grants[$];
    int multi_hot;
    int stray;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got 0 expected 1");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $finish;
    end

    initial begin
        do_reset();
        chk_en = 1'b1;

        // Single operation on requester 0 with hand-computed result and latency.
        req_valid = 4'b0001;
        req_op_a[31:0] = 32'h3FE0_0000;
        req_op_b[31:0] = 32'h4000_0000;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'h1);
        cnt = 0;
        do begin
            step();
            req_valid = '0;
            cnt++;
        end while (rsp_valid == '0 && cnt < 200);
        check("t1_latency", cnt, WAIT_CYCLES + 1);
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_data", rsp_data, 32'h7FE0_0000);
        check("t1_rsp_status", 32'(rsp_status), 32'd3);
        rsp_ready = 4'b0001;
        step();
        check("t1_ops_done", 32'(ops_done), 32'd1);
        check("t1_rsp_cleared", 32'(rsp_valid), 32'd0);

        // All requesters busy: grants must rotate 0,1,2,3,0.
        do_reset();
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        multi_hot = 0;
        cnt = 0;
        while (grants.size() < 5 && cnt < 1000) begin
            #1;
            if ($countones(rsp_valid) > 1) multi_hot++;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) grants.push_back(i);
            step();
            cnt++;
        end
        check("t2_grant_count", grants.size(), 5);
        for (int i = 0; i < grants.size(); i++) check($sformatf("t2_grant%0d", i), grants[i], i % NREQ);
        check("t2_onehot", multi_hot, 0);

        // Requester 2 stalls its response while the stub output keeps changing.
        do_reset();
        req_valid = 4'b0100;
        req_op_a[95:64] = 32'h1234_5678;
        req_op_b[95:64] = 32'h0F0F_0F0F;
        step();
        req_valid = '0;
        rsp_ready = 4'b0010;
        mask_rand = 1'b1;
        cnt = 0;
        while (rsp_valid == '0 && cnt < 200) begin
            step();
            cnt++;
        end
        check("t3_reached_respond", 32'(cnt < 200), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("t3_rsp_valid", 32'(rsp_valid), 32'h4);
            check("t3_rsp_data", rsp_data, 32'h1234_5678 ^ 32'h0F0F_0F0F ^ (m_data ^ 32'h1234_5678 ^ 32'h0F0F_0F0F));
            step();
        end
        check("t3_ops_held", 32'(ops_done), 32'd0);
        rsp_ready = 4'b0100;
        step();
        check("t3_ops_done", 32'(ops_done), 32'd1);
        mask_rand = 1'b0;

        // Reset pulse mid-window abandons the operation and clears the pointer.
        do_reset();
        req_valid = 4'b1000;
        req_op_a[127:96] = 32'hDEAD_BEEF;
        step();
        req_valid = '0;
        for (int i = 0; i < 33; i++) step();
        reset = 1'b0;
        #1;
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t4_grant_id", 32'(grant_id), 32'd0);
        check("t4_fpu_op_a", fpu_op_a, 32'd0);
        check("t4_rsp_status", 32'(rsp_status), 32'd2);
        step();
        step();
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < WAIT_CYCLES + 10; i++) begin
            step();
            if (rsp_valid != '0) stray++;
        end
        check("t4_no_stray_rsp", stray, 0);
        req_valid = 4'b1111;
        #1;
        check("t4_rr_ptr_zero", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;

        // Counter wrap: 17 completions with a 4-bit count.
        do_reset();
        rsp_ready = 4'b1111;
        cnt = 0;
        stray = 0;
        while (cnt < 17 && stray < 3000) begin
            req_valid = 4'b0001 << $urandom_range(0, 3);
            step();
            stray++;
            if (rsp_valid != '0) cnt++;
        end
        step();
        check("t5_ops_wrap", 32'(ops_done), 32'd1);

        // Random traffic, checked every cycle by the model.
        do_reset();
        mask_rand = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            req_valid = NREQ'($urandom);
            rsp_ready = NREQ'($urandom);
            req_op_a  = {$urandom, $urandom, $urandom, $urandom};
            req_op_b  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        check("rand_progress", 32'(m_ops != ops_done), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
